exec_sequencer: RTL

Multi-cycle stage controller for the Pillar core. It walks each instruction through FETCH, DECODE, EXECUTE, MEM and WRITEBACK, and owns the PC and the instruction register. It drives the stage number, the operand latch strobes and the instruction word consumed by the ALU. It also handshakes with instruction and data memory and produces register-file write enable and retire pulses.

---
 rtl/exec_sequencer_if.sv | 30 +++
 rtl/exec_sequencer.sv | 77 +++++++
 2 files changed

// File: rtl/exec_sequencer_if.sv
// exec_sequencer_if: memory handshake, decoder and ALU-control signals of the stage sequencer
interface exec_sequencer_if;
  logic        imem_ack_i;
  logic [31:0] imem_data_i;
  logic        dmem_ack_i;
  logic [4:0]  itype_i;
  logic        redirect_i;
  logic [31:0] target_i;
  logic [2:0]  stage_o;
  logic [31:0] pc_o;
  logic [31:0] ir_o;
  logic        imem_req_o;
  logic        dmem_req_o;
  logic        readin_a_o;
  logic        readin_b_o;
  logic        readin_pass_o;
  logic        rf_we_o;
  logic        retire_o;
  logic        illegal_o;
  modport slave (
    input  imem_ack_i, imem_data_i, dmem_ack_i, itype_i, redirect_i, target_i,
    output stage_o, pc_o, ir_o, imem_req_o, dmem_req_o, readin_a_o, readin_b_o,
           readin_pass_o, rf_we_o, retire_o, illegal_o
  );
  modport master (
    output imem_ack_i, imem_data_i, dmem_ack_i, itype_i, redirect_i, target_i,
    input  stage_o, pc_o, ir_o, imem_req_o, dmem_req_o, readin_a_o, readin_b_o,
           readin_pass_o, rf_we_o, retire_o, illegal_o
  );
endinterface

// File: rtl/exec_sequencer.sv
// exec_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WRITEBACK controller owning PC and IR
module exec_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic clk,
  input logic reset,
  exec_sequencer_if.slave bus
);
  localparam logic [4:0] RTYPE = 5'd0, ITYPE = 5'd1, STYPE = 5'd2, BTYPE = 5'd3, UTYPE = 5'd4, JTYPE = 5'd5;
  typedef enum logic [2:0] {
    S_IDLE = 3'd0, S_FETCH = 3'd1, S_DECODE = 3'd2, S_EXEC = 3'd3, S_MEM = 3'd4, S_WB = 3'd5
  } state_t;
  state_t      r_state, w_next;
  logic [31:0] r_pc, r_npc, r_ir;
  logic        r_imem_req, r_dmem_req, r_readin, r_rf_we, r_retire, r_illegal;
  logic        w_ls, w_writes, w_known;
  logic        w_imem_req, w_dmem_req, w_readin, w_rf_we, w_retire, w_illegal;
  assign w_ls     = r_ir[6:0] == 7'b0000011 || r_ir[6:0] == 7'b0100011;
  assign w_writes = bus.itype_i == RTYPE || bus.itype_i == ITYPE || bus.itype_i == UTYPE || bus.itype_i == JTYPE;
  assign w_known  = w_writes || bus.itype_i == STYPE || bus.itype_i == BTYPE;
  always_ff @(posedge clk)
    r_state <= reset ? S_IDLE : w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_FETCH;
      S_FETCH:  w_next = bus.imem_ack_i ? S_DECODE : S_FETCH;
      S_DECODE: w_next = S_EXEC;
      S_EXEC:   w_next = w_ls ? S_MEM : S_WB;
      S_MEM:    w_next = bus.dmem_ack_i ? S_WB : S_MEM;
      S_WB:     w_next = S_FETCH;
      default:  w_next = S_IDLE;
    endcase
  end
  // outputs are registered, so they are decoded from the state being entered
  always_comb begin
    w_imem_req = w_next == S_FETCH;
    w_dmem_req = w_next == S_MEM;
    w_readin   = w_next == S_DECODE;
    w_retire   = w_next == S_WB;
    w_rf_we    = w_retire && w_writes && r_ir[11:7] != 5'd0;
    w_illegal  = w_retire && !w_known;
  end
  always_ff @(posedge clk)
    if (reset) begin
      r_pc       <= RESET_PC;
      r_npc      <= RESET_PC;
      r_ir       <= 32'd0;
      r_imem_req <= 1'b0;
      r_dmem_req <= 1'b0;
      r_readin   <= 1'b0;
      r_rf_we    <= 1'b0;
      r_retire   <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      if (r_state == S_FETCH && bus.imem_ack_i) r_ir <= bus.imem_data_i;
      if (r_state == S_EXEC) r_npc <= bus.redirect_i ? bus.target_i : r_pc + 32'd4;
      if (r_state == S_WB) r_pc <= r_npc;
      r_imem_req <= w_imem_req;
      r_dmem_req <= w_dmem_req;
      r_readin   <= w_readin;
      r_rf_we    <= w_rf_we;
      r_retire   <= w_retire;
      r_illegal  <= w_illegal;
    end
  assign bus.stage_o       = r_state;
  assign bus.pc_o          = r_pc;
  assign bus.ir_o          = r_ir;
  assign bus.imem_req_o    = r_imem_req;
  assign bus.dmem_req_o    = r_dmem_req;
  assign bus.readin_a_o    = r_readin;
  assign bus.readin_b_o    = r_readin;
  assign bus.readin_pass_o = r_readin;
  assign bus.rf_we_o       = r_rf_we;
  assign bus.retire_o      = r_retire;
  assign bus.illegal_o     = r_illegal;
endmodule
